// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the register-file writeback port arbiter: requester
// indices and the queued write entry (destination register + data).
// -----------------------------------------------------------------------------
package wb_pkg;

    localparam int WB_ALU    = 0;
    localparam int WB_MEM    = 1;
    localparam int WB_FFT    = 2;
    localparam int WB_NUMREQ = 3;

    localparam int WB_REGW  = 3;
    localparam int WB_DATAW = 32;

    typedef struct packed {
        logic [WB_REGW-1:0]  idx;
        logic [WB_DATAW-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// DEPTH-entry synchronous FIFO of wb_entry_t. Read and write pointers carry one
// extra wrap bit so full and empty are told apart without a separate flag.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset (empties the FIFO)
//   push, din      enqueue din (ignored when full)
//   pop            dequeue the head (ignored when empty)
//   head           current head entry (undefined content when empty)
//   empty, full    occupancy flags
//   count          number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  wb_entry_t                din,
    output wb_entry_t                head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_q, wr_d;
    logic [AW:0] rd_q, rd_d;
    wb_entry_t   mem_q [DEPTH];

    assign count = wr_q - rd_q;
    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign head  = mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push && !full) wr_d = wr_q + (AW+1)'(1);
        if (pop && !empty) rd_d = rd_q + (AW+1)'(1);
    end

    // NOTE: non-blocking (<=) for all clocked state so every register samples
    // the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone decide
    // which slots hold valid data, so this maps onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (push && !full) mem_q[wr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
// Shares the register file's single write port between NUMREQ writeback
// requesters (0=ALU, 1=MEM, 2=FFT). Each requester owns a small FIFO; a
// round-robin scheduler drains one entry per cycle. A per-register pending
// counter drives reg_busy so decode can stall on queued writes.
// Optional build macro WB_BYPASS_EN: an empty-FIFO requester presenting a
// write is also a candidate and, if granted, goes straight to the port.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid/req_reg/req_data     per-requester write request (packed slices)
//   req_ready                      per-requester FIFO not full (registered)
//   reg_wr_en/wr_reg/wr_data       register file write port
//   reg_busy                       bit r set while a write to r is queued
//   idle                           all FIFOs empty
// -----------------------------------------------------------------------------
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int DATAW        = WB_DATAW,
    parameter int REGW         = WB_REGW,
    parameter int NUMREGISTERS = 8,
    parameter int NUMREQ       = WB_NUMREQ,
    parameter int DEPTH        = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUMREQ-1:0]         req_valid,
    input  logic [NUMREQ*REGW-1:0]    req_reg,
    input  logic [NUMREQ*DATAW-1:0]   req_data,
    output logic [NUMREQ-1:0]         req_ready,
    output logic                      reg_wr_en,
    output logic [REGW-1:0]           wr_reg,
    output logic [DATAW-1:0]          wr_data,
    output logic [NUMREGISTERS-1:0]   reg_busy,
    output logic                      idle
);

    localparam int PW  = $clog2(NUMREQ);
    localparam int CW  = $clog2(NUMREQ*DEPTH+1);
    localparam int FCW = $clog2(DEPTH) + 1;

    wb_entry_t          fifo_din  [NUMREQ];
    wb_entry_t          fifo_head [NUMREQ];
    logic [FCW-1:0]     fifo_count[NUMREQ];
    logic [NUMREQ-1:0]  fifo_empty, fifo_full;
    logic [NUMREQ-1:0]  cand, gnt_oh, push, pop, byp_win;
    logic               gnt_valid;
    logic [PW-1:0]      gnt_idx;
    logic [PW-1:0]      ptr_q, ptr_d;
    wb_entry_t          wr_ent;
    logic [CW-1:0]      cnt_q [NUMREGISTERS];
    logic [CW-1:0]      cnt_d [NUMREGISTERS];

    for (genvar g = 0; g < NUMREQ; g++) begin : g_req
        assign fifo_din[g] = '{idx: req_reg[g*REGW +: REGW], data: req_data[g*DATAW +: DATAW]};

        wb_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[g]),
            .pop   (pop[g]),
            .din   (fifo_din[g]),
            .head  (fifo_head[g]),
            .empty (fifo_empty[g]),
            .full  (fifo_full[g]),
            .count (fifo_count[g])
        );
    end

    // Ready depends on registered occupancy only, so it stays low in a cycle a
    // full FIFO pops.
    assign req_ready = ~fifo_full;

    always_comb begin
        idle = 1'b1;
        for (int i = 0; i < NUMREQ; i++) begin
            if (fifo_count[i] != '0) idle = 1'b0;
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned (which would infer a latch).
    always_comb begin
        int idx;
        idx       = 0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        gnt_oh    = '0;
`ifdef WB_BYPASS_EN
        // Bypass is masked during reset so the port stays quiet while held.
        cand = ~fifo_empty | (fifo_empty & req_valid & {NUMREQ{rst_n}});
`else
        cand = ~fifo_empty;
`endif
        // First candidate strictly after the last winner, wrapping.
        for (int k = 1; k <= NUMREQ; k++) begin
            idx = (int'(ptr_q) + k) % NUMREQ;
            if (!gnt_valid && cand[idx]) begin
                gnt_valid   = 1'b1;
                gnt_idx     = PW'(idx);
                gnt_oh[idx] = 1'b1;
            end
        end

        pop     = gnt_oh & ~fifo_empty;
        byp_win = gnt_oh & fifo_empty;
        // A bypassed write is consumed by the port, never enqueued.
        push    = req_valid & req_ready & ~byp_win;

        wr_ent = '0;
        if (gnt_valid) begin
            wr_ent = fifo_empty[gnt_idx] ? fifo_din[gnt_idx] : fifo_head[gnt_idx];
        end
        ptr_d = gnt_valid ? gnt_idx : ptr_q;
    end

    assign reg_wr_en = gnt_valid;
    assign wr_reg    = wr_ent.idx;
    assign wr_data   = wr_ent.data;

    // Pending counters: enqueues add, a FIFO-sourced write retires one; both
    // are netted into a single update.
    always_comb begin
        for (int r = 0; r < NUMREGISTERS; r++) begin
            cnt_d[r] = cnt_q[r];
            for (int i = 0; i < NUMREQ; i++) begin
                if (push[i] && fifo_din[i].idx == REGW'(r)) cnt_d[r] = cnt_d[r] + CW'(1);
            end
            if ((|pop) && wr_ent.idx == REGW'(r)) cnt_d[r] = cnt_d[r] - CW'(1);
        end
    end

    always_comb begin
        for (int r = 0; r < NUMREGISTERS; r++) reg_busy[r] = (cnt_q[r] != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= PW'(NUMREQ - 1);
            for (int r = 0; r < NUMREGISTERS; r++) cnt_q[r] <= '0;
        end else begin
            ptr_q <= ptr_d;
            for (int r = 0; r < NUMREGISTERS; r++) cnt_q[r] <= cnt_d[r];
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_port_arbiter
// Self-checking bench: a queue-based reference model is compared against the
// DUT on every falling edge; directed sequences add literal expectations.
// Honours WB_BYPASS_EN when the design is built with it.
// -----------------------------------------------------------------------------
module tb_wb_port_arbiter;

    localparam int NUMREQ = 3;
    localparam int REGW   = 3;
    localparam int DATAW  = 32;
    localparam int NREG   = 8;
    localparam int DEPTH  = 2;

    logic                    clk;
    logic                    rst_n;
    logic [NUMREQ-1:0]       req_valid;
    logic [NUMREQ*REGW-1:0]  req_reg;
    logic [NUMREQ*DATAW-1:0] req_data;
    logic [NUMREQ-1:0]       req_ready;
    logic                    reg_wr_en;
    logic [REGW-1:0]         wr_reg;
    logic [DATAW-1:0]        wr_data;
    logic [NREG-1:0]         reg_busy;
    logic                    idle;

    int checks = 0;
    int errors = 0;

    wb_port_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_reg   (req_reg),
        .req_data  (req_data),
        .req_ready (req_ready),
        .reg_wr_en (reg_wr_en),
        .wr_reg    (wr_reg),
        .wr_data   (wr_data),
        .reg_busy  (reg_busy),
        .idle      (idle)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [REGW+DATAW-1:0] mq [NUMREQ][$];
    int                    mptr;
    logic [REGW+DATAW-1:0] wr_log[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_wr_en", reg_wr_en, 0);
            check("rst_wr_reg", wr_reg, 0);
            check("rst_wr_data", wr_data, 0);
            check("rst_busy", reg_busy, 0);
            check("rst_idle", idle, 1);
            check("rst_ready", req_ready, 3'b111);
            for (int i = 0; i < NUMREQ; i++) mq[i].delete();
            mptr = NUMREQ - 1;
        end else begin
            int                    g;
            bit                    byp;
            bit                    acc[NUMREQ];
            logic [REGW+DATAW-1:0] ent;
            logic [NREG-1:0]       busy_e;
            logic [NUMREQ-1:0]     rdy_e;
            bit                    idle_e;
            g = -1;
            byp = 0;
            ent = '0;
            for (int k = 1; k <= NUMREQ; k++) begin
                int i;
                bit c;
                i = (mptr + k) % NUMREQ;
                c = (mq[i].size() > 0);
`ifdef WB_BYPASS_EN
                c = c || (req_valid[i] == 1'b1);
`endif
                if (g < 0 && c) g = i;
            end
            if (g >= 0) begin
                if (mq[g].size() > 0) ent = mq[g][0];
                else begin
                    ent = {req_reg[g*REGW +: REGW], req_data[g*DATAW +: DATAW]};
                    byp = 1;
                end
            end
            busy_e = '0;
            idle_e = 1;
            for (int i = 0; i < NUMREQ; i++) begin
                rdy_e[i] = (mq[i].size() < DEPTH);
                if (mq[i].size() > 0) idle_e = 0;
                foreach (mq[i][j]) busy_e[mq[i][j][REGW+DATAW-1:DATAW]] = 1'b1;
            end
            check("wr_en", reg_wr_en, (g >= 0));
            check("wr_reg", wr_reg, ent[REGW+DATAW-1:DATAW]);
            check("wr_data", wr_data, ent[DATAW-1:0]);
            check("busy", reg_busy, busy_e);
            check("ready", req_ready, rdy_e);
            check("idle", idle, idle_e);
            if (reg_wr_en) wr_log.push_back({wr_reg, wr_data});
            for (int i = 0; i < NUMREQ; i++)
                acc[i] = req_valid[i] && (mq[i].size() < DEPTH) && !(byp && g == i);
            if (g >= 0 && !byp) void'(mq[g].pop_front());
            for (int i = 0; i < NUMREQ; i++)
                if (acc[i]) mq[i].push_back({req_reg[i*REGW +: REGW], req_data[i*DATAW +: DATAW]});
            if (g >= 0) mptr = g;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid = '0;
        req_reg   = '0;
        req_data  = '0;
    endtask

    task automatic drive(input int i, input logic [REGW-1:0] r, input logic [DATAW-1:0] d);
        req_valid[i]               = 1'b1;
        req_reg[i*REGW +: REGW]    = r;
        req_data[i*DATAW +: DATAW] = d;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) next_cycle();
        rst_n = 1'b1;
        wr_log.delete();
    endtask

    initial begin
        int fft_sent;
        bit saw_not_ready;
        int fft_seen;
        logic [2:0] rr_exp [6];

        // Reset with all requesters asserting.
        rst_n = 1'b0;
        clear_inputs();
        req_valid = 3'b111;
        req_data  = {3{32'h1234_5678}};
        @(negedge clk);
        check("lit_rst_wr_en", reg_wr_en, 0);
        check("lit_rst_busy", reg_busy, 0);
        check("lit_rst_idle", idle, 1);
        check("lit_rst_ready", req_ready, 3'b111);
        next_cycle();
        clear_inputs();
        rst_n = 1'b1;
        wr_log.delete();
        repeat (3) next_cycle();
        check("lit_no_req_writes", wr_log.size(), 0);

        // Single write.
        do_reset();
        drive(0, 3'd3, 32'hDEAD_BEEF);
        @(negedge clk);
`ifdef WB_BYPASS_EN
        check("lit_single_byp_en", reg_wr_en, 1);
        check("lit_single_byp_reg", wr_reg, 3);
        check("lit_single_byp_data", wr_data, 32'hDEAD_BEEF);
`else
        check("lit_single_acc_en", reg_wr_en, 0);
`endif
        next_cycle();
        clear_inputs();
        @(negedge clk);
`ifdef WB_BYPASS_EN
        check("lit_single_busy", reg_busy[3], 0);
`else
        check("lit_single_en", reg_wr_en, 1);
        check("lit_single_reg", wr_reg, 3);
        check("lit_single_data", wr_data, 32'hDEAD_BEEF);
        check("lit_single_busy", reg_busy[3], 1);
`endif
        next_cycle();
        @(negedge clk);
        check("lit_single_busy_after", reg_busy[3], 0);
        check("lit_single_en_after", reg_wr_en, 0);

        // Round robin, two pushes from all three requesters.
        do_reset();
        drive(0, 3'd1, 32'h1); drive(1, 3'd2, 32'h2); drive(2, 3'd4, 32'h4);
        next_cycle();
        drive(0, 3'd1, 32'h1); drive(1, 3'd2, 32'h2); drive(2, 3'd4, 32'h4);
        next_cycle();
        clear_inputs();
        repeat (8) next_cycle();
        rr_exp = '{3'd1, 3'd2, 3'd4, 3'd1, 3'd2, 3'd4};
        check("lit_rr_count", wr_log.size(), 6);
        for (int k = 0; k < 6 && k < wr_log.size(); k++)
            check($sformatf("lit_rr_order%0d", k), wr_log[k][REGW+DATAW-1:DATAW], rr_exp[k]);
        check("lit_rr_idle", idle, 1);

        // Same register from ALU and MEM in one cycle.
        do_reset();
        drive(0, 3'd5, 32'hA5A5); drive(1, 3'd5, 32'h5A5A);
        next_cycle();
        clear_inputs();
        @(negedge clk);
        check("lit_same_busy", reg_busy[5], 1);
        repeat (4) next_cycle();
        check("lit_same_busy_clear", reg_busy[5], 0);
        check("lit_same_count", wr_log.size(), 2);
        if (wr_log.size() == 2) begin
            check("lit_same_first", wr_log[0][DATAW-1:0], 32'hA5A5);
            check("lit_same_second", wr_log[1][DATAW-1:0], 32'h5A5A);
        end

        // Backpressure: FFT sends 3 while ALU floods.
        do_reset();
        fft_sent = 0;
        saw_not_ready = 0;
        for (int cyc = 0; cyc < 40 && fft_sent < 3; cyc++) begin
            drive(0, 3'($urandom_range(0, 7)), 32'h100 + cyc);
            drive(2, 3'd6, 32'hF0 + fft_sent);
            @(negedge clk);
            if (req_ready[2]) fft_sent++;
            else saw_not_ready = 1;
            next_cycle();
        end
        clear_inputs();
        repeat (10) next_cycle();
        check("lit_bp_sent", fft_sent, 3);
`ifndef WB_BYPASS_EN
        check("lit_bp_ready_dropped", saw_not_ready, 1);
`endif
        fft_seen = 0;
        foreach (wr_log[k]) begin
            if (wr_log[k][DATAW-1:0] >= 32'hF0 && wr_log[k][DATAW-1:0] <= 32'hF2) begin
                check($sformatf("lit_bp_fft%0d", fft_seen), wr_log[k][DATAW-1:0], 32'hF0 + fft_seen);
                fft_seen++;
            end
        end
        check("lit_bp_fft_seen", fft_seen, 3);

        // Reset with writes queued: they must vanish.
        do_reset();
        drive(0, 3'd0, 32'h7700); drive(1, 3'd1, 32'h7701); drive(2, 3'd2, 32'h7702);
        next_cycle();
        drive(0, 3'd3, 32'h7703); drive(1, 3'd4, 32'h7704); drive(2, 3'd5, 32'h7705);
        next_cycle();
        clear_inputs();
        #1;
        rst_n = 1'b0;
        #1;
        check("lit_mid_rst_en", reg_wr_en, 0);
        check("lit_mid_rst_busy", reg_busy, 0);
        check("lit_mid_rst_idle", idle, 1);
        check("lit_mid_rst_ready", req_ready, 3'b111);
        next_cycle();
        rst_n = 1'b1;
        wr_log.delete();
        repeat (10) next_cycle();
        check("lit_mid_rst_dropped", wr_log.size(), 0);

        // Randomized traffic with occasional resets.
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            req_valid = 3'($urandom());
            req_reg   = 9'($urandom());
            req_data  = {$urandom(), $urandom(), $urandom()};
            rst_n     = ($urandom_range(0, 199) != 0);
            next_cycle();
        end
        rst_n = 1'b1;
        clear_inputs();
        repeat (10) next_cycle();
        check("end_idle", idle, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
